// File: rtl/hyperbus_native_responder.sv
// Hyperbus native-interface memory responder: answers rrq/wrq bursts from a 16-bit-word RAM
// after a programmable initial latency, with optional periodic beat throttling.
module hyperbus_native_responder #(
  parameter int unsigned HBUS_ADDR_WIDTH = 32,
  parameter int unsigned HBUS_DATA_WIDTH = 16,
  parameter int unsigned MEM_ADDR_BITS   = 10,
  parameter int unsigned LATENCY         = 4,
  parameter int unsigned STALL_EVERY     = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [HBUS_ADDR_WIDTH-1:0]   hbus_adr_i,
  input  logic [HBUS_DATA_WIDTH-1:0]   hbus_dat_i,
  input  logic [HBUS_DATA_WIDTH/8-1:0] hbus_mask_i,
  output logic [HBUS_DATA_WIDTH-1:0]   hbus_dat_o,
  input  logic                         hbus_rrq,
  input  logic                         hbus_wrq,
  output logic                         hbus_ready,
  output logic                         hbus_valid,
  output logic                         busy,
  output logic                         err
);

  localparam int unsigned NumBytes = HBUS_DATA_WIDTH / 8;
  localparam int unsigned Depth    = 2 ** MEM_ADDR_BITS;
  localparam int unsigned BcntW    = (STALL_EVERY > 1) ? $clog2(STALL_EVERY + 1) : 1;

  typedef enum logic [1:0] {StIdle, StLat, StRd, StWr} state_e;

  state_e                     state_q, state_d;
  logic [MEM_ADDR_BITS-1:0]   ptr_q, ptr_d;
  logic [7:0]                 cnt_q, cnt_d;
  logic                       dir_wr_q, dir_wr_d;
  logic [BcntW-1:0]           bcnt_q, bcnt_d;
  logic                       ready_q, ready_d;
  logic                       valid_q, valid_d;
  logic                       busy_q;
  logic                       err_q, err_d;
  logic [HBUS_DATA_WIDTH-1:0] dat_q;
  logic                       rd_en;
  logic                       mem_we;
  logic                       xfer;
  logic                       stall;
  logic                       req_act;
  logic [BcntW:0]             bcnt_inc;

  logic [HBUS_DATA_WIDTH-1:0] mem [Depth];

  // A beat counts as transferred when the master still holds its request while the
  // registered valid/ready is high; the stall decision looks at the post-beat count.
  assign mem_we   = rst_n & (state_q == StWr) & ready_q & hbus_wrq;
  assign xfer     = ((state_q == StRd) & valid_q & hbus_rrq) | mem_we;
  assign bcnt_inc = {1'b0, bcnt_q} + (BcntW + 1)'(xfer);
  assign stall    = (STALL_EVERY != 0) && (bcnt_inc == (BcntW + 1)'(STALL_EVERY));
  assign req_act  = dir_wr_q ? hbus_wrq : hbus_rrq;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    dir_wr_d = dir_wr_q;
    bcnt_d   = bcnt_q;
    ready_d  = 1'b0;
    valid_d  = 1'b0;
    err_d    = err_q;
    rd_en    = 1'b0;
    case (state_q)
      StIdle: begin
        if (hbus_wrq || hbus_rrq) begin
          ptr_d    = hbus_adr_i[MEM_ADDR_BITS-1:0];
          cnt_d    = 8'(LATENCY - 1);
          dir_wr_d = hbus_wrq;
          bcnt_d   = '0;
          state_d  = StLat;
        end
        if (hbus_wrq && hbus_rrq) err_d = 1'b1;
      end
      StLat: begin
        if (!req_act) begin
          state_d = StIdle;
        end else if (cnt_q == 8'd0) begin
          if (dir_wr_q) begin
            state_d = StWr;
            ready_d = 1'b1;
          end else begin
            state_d = StRd;
            valid_d = 1'b1;
            rd_en   = 1'b1;
            ptr_d   = ptr_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StRd: begin
        if (!hbus_rrq) begin
          state_d = StIdle;
        end else begin
          bcnt_d = stall ? '0 : bcnt_inc[BcntW-1:0];
          if (!stall) begin
            valid_d = 1'b1;
            rd_en   = 1'b1;
            ptr_d   = ptr_q + 1'b1;
          end
        end
      end
      StWr: begin
        if (!hbus_wrq) begin
          state_d = StIdle;
        end else begin
          bcnt_d  = stall ? '0 : bcnt_inc[BcntW-1:0];
          ready_d = !stall;
          if (xfer) ptr_d = ptr_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      cnt_q    <= '0;
      dir_wr_q <= 1'b0;
      bcnt_q   <= '0;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      dat_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      dir_wr_q <= dir_wr_d;
      bcnt_q   <= bcnt_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      busy_q   <= (state_d != StIdle);
      err_q    <= err_d;
      if (rd_en) dat_q <= mem[ptr_q];
    end
  end

  // RAM contents survive reset, so the array has no reset branch.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NumBytes; i++) begin
        if (!hbus_mask_i[i]) mem[ptr_q][8*i +: 8] <= hbus_dat_i[8*i +: 8];
      end
    end
  end

  assign hbus_dat_o = dat_q;
  assign hbus_ready = ready_q;
  assign hbus_valid = valid_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule

// File: tb/tb_hyperbus_native_responder.sv
// Directed bench for hyperbus_native_responder: table of 1-2 beat bursts plus hand-written
// reset, abort, error and throttle sequences (LATENCY=4, STALL_EVERY=2, 1K words).
module tb_hyperbus_native_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] adr = '0;
  logic [15:0] dat = '0;
  logic [1:0]  mask = '0;
  logic [15:0] dat_o;
  logic        rrq = 1'b0;
  logic        wrq = 1'b0;
  logic        ready, valid, busy, err;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hyperbus_native_responder #(
    .HBUS_ADDR_WIDTH(32),
    .HBUS_DATA_WIDTH(16),
    .MEM_ADDR_BITS  (10),
    .LATENCY        (4),
    .STALL_EVERY    (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hbus_adr_i (adr),
    .hbus_dat_i (dat),
    .hbus_mask_i(mask),
    .hbus_dat_o (dat_o),
    .hbus_rrq   (rrq),
    .hbus_wrq   (wrq),
    .hbus_ready (ready),
    .hbus_valid (valid),
    .busy       (busy),
    .err        (err)
  );

  // a0/a1: write data for writes, expected read data for reads
  typedef struct {
    logic        wr;
    logic        both;
    logic [31:0] adr;
    int          n;
    logic [15:0] a0;
    logic [15:0] a1;
    logic [1:0]  mask;
  } vec_t;

  vec_t tbl[12];

  function automatic vec_t mk(logic wr, logic both, logic [31:0] a, int n,
                              logic [15:0] a0, logic [15:0] a1, logic [1:0] m);
    vec_t v;
    v.wr = wr; v.both = both; v.adr = a; v.n = n; v.a0 = a0; v.a1 = a1; v.mask = m;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Request goes high in cycle 0; first ready/valid is expected in cycle 5.
  task automatic run_burst(input vec_t v, input int idx);
    int   k;
    int   first;
    logic rdy;
    @(posedge clk); #1;
    adr = v.adr; dat = v.a0; mask = v.mask;
    if (v.wr) begin
      wrq = 1'b1; rrq = v.both;
    end else begin
      rrq = 1'b1;
    end
    k = 0; first = -1;
    for (int c = 0; c < 40 && k < v.n; c++) begin
      @(negedge clk);
      if (v.wr) begin
        rdy = ready;
        if (rdy && first < 0) first = c;
        @(posedge clk); #1;
        if (rdy) begin
          k++; dat = v.a1;
        end
      end else begin
        if (valid) begin
          if (first < 0) first = c;
          check($sformatf("v%0d rd beat%0d", idx, k), {16'h0, dat_o},
                {16'h0, (k == 0) ? v.a0 : v.a1});
          k++;
        end
        @(posedge clk); #1;
      end
    end
    rrq = 1'b0; wrq = 1'b0;
    check($sformatf("v%0d first beat cycle", idx), first, 5);
    check($sformatf("v%0d beat count", idx), k, v.n);
    @(negedge clk);
    @(negedge clk);
    check($sformatf("v%0d idle after", idx), {29'h0, busy, valid, ready}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic        anyv;
    logic [4:0]  pat;
    logic [15:0] got[4];
    int          k;

    tbl[0]  = mk(1, 0, 32'h10,   2, 16'hDEAD, 16'hBEEF, 2'b00);
    tbl[1]  = mk(0, 0, 32'h10,   2, 16'hDEAD, 16'hBEEF, 2'b00);
    tbl[2]  = mk(1, 0, 32'h11,   1, 16'h1234, 16'h0000, 2'b10);
    tbl[3]  = mk(0, 0, 32'h10,   2, 16'hDEAD, 16'hBE34, 2'b00);
    tbl[4]  = mk(1, 0, 32'h3FF,  2, 16'hAAAA, 16'h5555, 2'b00);
    tbl[5]  = mk(0, 0, 32'h3FF,  2, 16'hAAAA, 16'h5555, 2'b00);
    tbl[6]  = mk(0, 0, 32'h0,    1, 16'h5555, 16'h0000, 2'b00);
    tbl[7]  = mk(1, 0, 32'h13FF, 2, 16'h1111, 16'h2222, 2'b00);
    tbl[8]  = mk(0, 0, 32'h3FF,  2, 16'h1111, 16'h2222, 2'b00);
    tbl[9]  = mk(0, 0, 32'h0,    1, 16'h2222, 16'h0000, 2'b00);
    tbl[10] = mk(1, 0, 32'h12,   2, 16'hCAFE, 16'hF00D, 2'b00);
    tbl[11] = mk(0, 0, 32'h11,   2, 16'hBE34, 16'hCAFE, 2'b00);

    // Reset held with both requests high must keep every output quiet.
    rrq = 1'b1; wrq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("reset flags %0d", i), {28'h0, ready, valid, busy, err}, 32'h0);
      check($sformatf("reset dat_o %0d", i), {16'h0, dat_o}, 32'h0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; rrq = 1'b0; wrq = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("idle after reset", {28'h0, ready, valid, busy, err}, 32'h0);

    for (int i = 0; i < 12; i++) run_burst(tbl[i], i);

    // Abort during latency: rrq high for cycles 0 and 1 only.
    @(posedge clk); #1;
    adr = 32'h10; rrq = 1'b1; anyv = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      anyv = anyv | valid;
      if (c == 1) check("abort busy during lat", {31'h0, busy}, 32'h1);
      @(posedge clk); #1;
      if (c == 1) rrq = 1'b0;
    end
    @(negedge clk);
    check("abort no valid", {31'h0, anyv}, 32'h0);
    check("abort busy low", {31'h0, busy}, 32'h0);
    check("err clear before clash", {31'h0, err}, 32'h0);

    // Both requests together: write wins, err latches.
    run_burst(mk(1, 1, 32'h30, 1, 16'h7777, 16'h0000, 2'b00), 12);
    check("err set", {31'h0, err}, 32'h1);
    run_burst(mk(0, 0, 32'h30, 1, 16'h7777, 16'h0000, 2'b00), 13);
    check("err sticky", {31'h0, err}, 32'h1);

    // Throttle: 4-beat read at 0x10, valid expected in cycles 5,6,8,9.
    @(posedge clk); #1;
    adr = 32'h10; rrq = 1'b1; pat = '0; k = 0;
    for (int c = 0; c < 40 && k < 4; c++) begin
      @(negedge clk);
      if (c >= 5 && c <= 9) pat[c-5] = valid;
      if (valid) begin
        got[k] = dat_o;
        k++;
      end
      @(posedge clk); #1;
    end
    rrq = 1'b0;
    check("throttle beats", k, 4);
    check("throttle valid pattern", {27'h0, pat}, 32'b11011);
    check("throttle d0", {16'h0, got[0]}, 32'hDEAD);
    check("throttle d1", {16'h0, got[1]}, 32'hBE34);
    check("throttle d2", {16'h0, got[2]}, 32'hCAFE);
    check("throttle d3", {16'h0, got[3]}, 32'hF00D);
    @(negedge clk);
    @(negedge clk);
    check("throttle idle after", {31'h0, busy}, 32'h0);

    // Reset clears the sticky error.
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("err cleared by reset", {31'h0, err}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
